// File: rtl/cache_axi_bridge.sv
// Bridges the i-cache and d-cache SRAM-like ports onto one AXI3 master port.
// One single-beat transaction is in flight at a time, and the d-side always wins arbitration.
module cache_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_B
    } state_t;

    state_t      state_reg, state_next;
    logic        sel_reg, sel_next;
    logic        wr_reg, wr_next;
    logic [1:0]  size_reg, size_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        aw_done_reg, aw_done_next;
    logic        w_done_reg, w_done_next;

    logic        grant_inst;
    logic        grant_data;
    logic        resp_done;
    logic        aw_hs;
    logic        w_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            sel_reg     <= 1'b0;
            wr_reg      <= 1'b0;
            size_reg    <= 2'd0;
            addr_reg    <= 32'd0;
            wdata_reg   <= 32'd0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            wr_reg      <= wr_next;
            size_reg    <= size_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
        end
    end

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        wr_next      = wr_reg;
        size_next    = size_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        resp_done    = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                if (data_req) begin
                    grant_data   = 1'b1;
                    sel_next     = 1'b1;
                    wr_next      = data_wr;
                    size_next    = data_size;
                    addr_next    = data_addr;
                    wdata_next   = data_wdata;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = data_wr ? S_AW : S_AR;
                end else if (inst_req) begin
                    grant_inst   = 1'b1;
                    sel_next     = 1'b0;
                    wr_next      = inst_wr;
                    size_next    = inst_size;
                    addr_next    = inst_addr;
                    wdata_next   = inst_wdata;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = inst_wr ? S_AW : S_AR;
                end
            end
            S_AR: begin
                if (arready) begin
                    state_next = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    resp_done  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_AW: begin
                // The two channels may complete in either order; leave once both have.
                if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    state_next   = S_B;
                end else begin
                    aw_done_next = aw_done_reg | aw_hs;
                    w_done_next  = w_done_reg | w_hs;
                end
            end
            S_B: begin
                if (bvalid) begin
                    resp_done  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Handshake outputs are masked during reset so an aborted transfer never reports completion.
    assign inst_addr_ok = grant_inst & ~rst;
    assign data_addr_ok = grant_data & ~rst;
    assign inst_data_ok = resp_done & ~sel_reg & ~rst;
    assign data_data_ok = resp_done & sel_reg & ~rst;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = AXI_ID;
    assign araddr  = addr_reg;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, size_reg};
    assign arburst = 2'b01;
    assign arvalid = (state_reg == S_AR);
    assign rready  = (state_reg == S_R);

    assign awid    = AXI_ID;
    assign awaddr  = addr_reg;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, size_reg};
    assign awburst = 2'b01;
    assign awvalid = (state_reg == S_AW) && !aw_done_reg;

    assign wid     = AXI_ID;
    assign wdata   = wdata_reg;
    assign wlast   = 1'b1;
    assign wvalid  = (state_reg == S_AW) && !w_done_reg;
    assign bready  = (state_reg == S_B);

    for (genvar gi = 0; gi < 4; gi++) begin : g_wstrb
        localparam logic [1:0] LANE = 2'(gi);
        assign wstrb[gi] = (size_reg == 2'd0) ? (addr_reg[1:0] == LANE) :
                           (size_reg == 2'd1) ? (addr_reg[1] == LANE[1]) :
                                                1'b1;
    end

    // Response metadata is not used by the caches.
    logic unused_ok;
    assign unused_ok = ^{rid, rresp, rlast, bid, bresp, wr_reg};

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Randomized self-checking bench for cache_axi_bridge: the bench plays both caches and the AXI slave,
// and compares against a byte-level memory model driven by the cache-side requests.
module tb_cache_axi_bridge;

    logic        clk;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid, arlen, awid, awlen, wid, rid, bid, wstrb;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [logic [31:0]];
    logic [7:0]  slv_mem [logic [31:0]];
    logic [31:0] slv_araddr, slv_awaddr, slv_wdata;
    logic [3:0]  slv_wstrb;

    cache_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ 8'h5a;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] b;
        w = 32'd0;
        for (int l = 0; l < 4; l++) begin
            b = {a[31:2], 2'b00} + 32'(l);
            w[8*l +: 8] = ref_mem.exists(b) ? ref_mem[b] : init_byte(b);
        end
        return w;
    endfunction

    function automatic logic [31:0] slv_word(input logic [31:0] a);
        logic [31:0] w;
        logic [31:0] b;
        w = 32'd0;
        for (int l = 0; l < 4; l++) begin
            b = {a[31:2], 2'b00} + 32'(l);
            w[8*l +: 8] = slv_mem.exists(b) ? slv_mem[b] : init_byte(b);
        end
        return w;
    endfunction

    // First byte lane of the naturally aligned access containing addr.
    function automatic int first_lane(input logic [1:0] size, input logic [31:0] addr);
        int n;
        n = 1 << size;
        return int'(addr[1:0]) - (int'(addr[1:0]) % n);
    endfunction

    function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < (1 << size); i++) s[first_lane(size, addr) + i] = 1'b1;
        return s;
    endfunction

    task automatic ref_write(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
        int lane;
        for (int i = 0; i < (1 << size); i++) begin
            lane = first_lane(size, addr) + i;
            ref_mem[{addr[31:2], 2'b00} + 32'(lane)] = wd[8*lane +: 8];
        end
    endtask

    task automatic slave_commit();
        for (int l = 0; l < 4; l++)
            if (slv_wstrb[l]) slv_mem[{slv_awaddr[31:2], 2'b00} + 32'(l)] = slv_wdata[8*l +: 8];
    endtask

    function automatic logic own_addr_ok(input bit side);
        return side ? data_addr_ok : inst_addr_ok;
    endfunction

    function automatic logic own_data_ok(input bit side);
        return side ? data_data_ok : inst_data_ok;
    endfunction

    function automatic logic [31:0] own_rdata(input bit side);
        return side ? data_rdata : inst_rdata;
    endfunction

    task automatic set_port(input bit side, input bit req, input bit wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wd);
        if (side) begin
            data_req = req; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
        end else begin
            inst_req = req; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wd;
        end
    endtask

    // One cache transaction; d1/d2/d3 are the slave's wait counts (read: ar, r; write: aw, w, b).
    task automatic do_txn(input bit side, input bit wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input int d1, input int d2, input int d3);
        int k;
        int phase;
        int last;
        int ncyc;
        bit done;
        k = 0; phase = 0; done = 0; ncyc = 0;
        last = (d1 > d2) ? d1 : d2;

        @(negedge clk);
        set_port(side, 1'b1, wr, size, addr, wd);
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        #1;
        check("addr_ok", 32'(own_addr_ok(side)), 32'd1);
        check("other_addr_ok", 32'(own_addr_ok(!side)), 32'd0);
        check("idle_channels", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
        check("idle_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        @(posedge clk);

        for (int cyc = 1; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            ncyc = cyc;
            set_port(side, 1'b0, 1'($urandom), 2'($urandom), $urandom, $urandom);
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; rdata = $urandom;
            if (!wr) begin
                if (phase == 0) arready = (k == d1);
                else begin
                    rvalid = (k == d2);
                    if (rvalid) rdata = slv_word(slv_araddr);
                end
            end else begin
                if (phase == 0) begin
                    awready = (k == d1);
                    wready  = (k == d2);
                end else bvalid = (k == d3);
            end
            #1;
            check("busy_addr_ok", 32'(own_addr_ok(side)), 32'd0);
            check("other_addr_ok", 32'(own_addr_ok(!side)), 32'd0);
            check("other_data_ok", 32'(own_data_ok(!side)), 32'd0);
            if (!wr && phase == 0) begin
                check("arvalid", 32'(arvalid), 32'd1);
                check("araddr", araddr, addr);
                check("arsize", 32'(arsize), 32'({1'b0, size}));
                check("arlen", 32'(arlen), 32'd0);
                check("arburst", 32'(arburst), 32'd1);
                check("arid", 32'(arid), 32'd0);
                check("rready_in_ar", 32'(rready), 32'd0);
                check("data_ok_in_ar", 32'(own_data_ok(side)), 32'd0);
                if (arvalid && arready) slv_araddr = araddr;
                if (k == d1) begin phase = 1; k = 0; end else k++;
            end else if (!wr) begin
                check("rready", 32'(rready), 32'd1);
                check("arvalid_in_r", 32'(arvalid), 32'd0);
                check("read_data_ok", 32'(own_data_ok(side)), 32'(rvalid));
                if (rvalid) begin
                    check("rdata", own_rdata(side), ref_word(addr));
                    done = 1;
                end else k++;
            end else if (phase == 0) begin
                check("awvalid", 32'(awvalid), 32'(k <= d1));
                check("wvalid", 32'(wvalid), 32'(k <= d2));
                if (k <= d1) begin
                    check("awaddr", awaddr, addr);
                    check("awsize", 32'(awsize), 32'({1'b0, size}));
                    check("awlen", 32'(awlen), 32'd0);
                    check("awburst", 32'(awburst), 32'd1);
                    check("awid", 32'(awid), 32'd0);
                end
                if (k <= d2) begin
                    check("wdata", wdata, wd);
                    check("wstrb", 32'(wstrb), 32'(exp_strb(size, addr)));
                    check("wlast", 32'(wlast), 32'd1);
                    check("wid", 32'(wid), 32'd0);
                end
                check("bready_in_aw", 32'(bready), 32'd0);
                check("data_ok_in_aw", 32'(own_data_ok(side)), 32'd0);
                if (awvalid && awready) slv_awaddr = awaddr;
                if (wvalid && wready) begin slv_wdata = wdata; slv_wstrb = wstrb; end
                if (k == last) begin slave_commit(); phase = 1; k = 0; end else k++;
            end else begin
                check("bready", 32'(bready), 32'd1);
                check("valids_in_b", 32'({awvalid, wvalid}), 32'd0);
                check("write_data_ok", 32'(own_data_ok(side)), 32'(bvalid));
                if (bvalid) begin
                    ref_write(size, addr, wd);
                    done = 1;
                end else k++;
            end
            @(posedge clk);
        end
        if (!done) check("txn_timeout", 32'(done), 32'd1);
        $display("txn %s %s size=%0d addr=%08h wdata=%08h delays=%0d/%0d/%0d cycles=%0d",
                 side ? "data" : "inst", wr ? "write" : "read ", size, addr, wd, d1, d2, d3, ncyc);
    endtask

    initial begin
        rst = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        set_port(1'b1, 1'b1, 1'b0, 2'd2, 32'h1000_0000, 32'd0);
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rid = 0; bid = 0; rresp = 0; bresp = 0; rlast = 1; rdata = 0;
        for (int l = 0; l < 4; l++) begin
            ref_mem[32'h1000_0004 + 32'(l)] = 8'(32'hDEAD_BEEF >> (8 * l));
            slv_mem[32'h1000_0004 + 32'(l)] = 8'(32'hDEAD_BEEF >> (8 * l));
        end

        repeat (3) begin
            @(negedge clk);
            check("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
            check("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
            check("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        end
        check("rst_araddr", araddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_arsize", 32'(arsize), 32'd0);
        check("rst_wstrb", 32'(wstrb), 32'b0001);
        @(posedge clk);
        #1;
        rst = 1'b0;
        data_req = 1'b0;

        // Directed cases from the plan.
        do_txn(1'b1, 1'b0, 2'd2, 32'h1000_0004, 32'd0, 0, 0, 0);
        check("deadbeef_model", ref_word(32'h1000_0004), 32'hDEAD_BEEF);
        do_txn(1'b1, 1'b1, 2'd0, 32'h1000_0003, 32'h0000_00AB, 0, 0, 1);
        do_txn(1'b1, 1'b1, 2'd2, 32'h1000_0008, 32'h1234_5678, 0, 3, 0);

        #1;
        set_port(1'b0, 1'b1, 1'b0, 2'd2, 32'h1000_0000, 32'd0);
        do_txn(1'b1, 1'b0, 2'd2, 32'h1000_0010, 32'd0, 0, 0, 0);
        do_txn(1'b0, 1'b0, 2'd2, 32'h1000_0000, 32'd0, 0, 0, 0);

        do_txn(1'b1, 1'b0, 2'd2, 32'h1000_0008, 32'd0, 5, 0, 0);

        // Reset while waiting for read data.
        @(negedge clk);
        set_port(1'b1, 1'b1, 1'b0, 2'd2, 32'h1000_0004, 32'd0);
        #1;
        check("rst_seq_addr_ok", 32'(data_addr_ok), 32'd1);
        @(posedge clk);
        @(negedge clk);
        data_req = 1'b0;
        arready = 1'b1;
        #1;
        check("rst_seq_arvalid", 32'(arvalid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 32'hCAFE_F00D;
        rst = 1'b1;
        #1;
        check("rst_seq_rready", 32'(rready), 32'd1);
        check("rst_seq_no_data_ok", 32'(data_data_ok), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rvalid = 1'b0;
        @(negedge clk);
        check("post_rst_rready", 32'(rready), 32'd0);
        check("post_rst_valids", 32'({arvalid, awvalid, wvalid, bready}), 32'd0);
        check("post_rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        do_txn(1'b0, 1'b0, 2'd2, 32'h1000_0004, 32'd0, 0, 0, 0);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 2));
            a = 32'h1000_0000 + 32'($urandom_range(0, 31));
            a = a - (a % (32'd1 << sz));
            do_txn(1'($urandom), 1'($urandom), sz, a, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
